// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter onto a single-port RAM.
// Round-robin on conflict, combinational grants, latency-1 read return with per-port hold.
module mem_port_arbiter #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  IF_REQ,
  input  logic [ADDR_WIDTH-1:0] IF_ADDR,
  output logic                  IF_GNT,
  output logic                  IF_VALID,
  output logic [SIZE-1:0]       IF_RDATA,
  input  logic                  D_REQ,
  input  logic                  D_WE,
  input  logic [ADDR_WIDTH-1:0] D_ADDR,
  input  logic [SIZE-1:0]       D_WDATA,
  output logic                  D_GNT,
  output logic                  D_VALID,
  output logic [SIZE-1:0]       D_RDATA,
  output logic                  MEM_EN,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [SIZE-1:0]       MEM_WDATA,
  input  logic [SIZE-1:0]       MEM_RDATA,
  output logic [15:0]           CONFLICT_CNT
);

  typedef enum logic {OWNER_IF, OWNER_D} owner_e;
  typedef enum logic [1:0] {RESP_NONE, RESP_IF, RESP_D} resp_e;

  owner_e          last_owner, last_owner_next;
  resp_e           resp_owner, resp_owner_next;
  logic            if_gnt, d_gnt;
  logic [SIZE-1:0] if_hold, d_hold;
  logic [15:0]     conflict_cnt;

  // Grants are gated by RESET_N so every strobe is low while reset is held.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (RESET_N) begin
      if (IF_REQ && D_REQ) begin
        if (last_owner == OWNER_IF) d_gnt  = 1'b1;
        else                        if_gnt = 1'b1;
      end else begin
        if_gnt = IF_REQ;
        d_gnt  = D_REQ;
      end
    end
  end

  always_comb begin
    last_owner_next = last_owner;
    resp_owner_next = RESP_NONE;
    if (if_gnt) begin
      last_owner_next = OWNER_IF;
      resp_owner_next = RESP_IF;
    end else if (d_gnt) begin
      last_owner_next = OWNER_D;
      resp_owner_next = D_WE ? RESP_NONE : RESP_D;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_owner <= OWNER_IF;
      resp_owner <= RESP_NONE;
    end else begin
      last_owner <= last_owner_next;
      resp_owner <= resp_owner_next;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      if_hold      <= '0;
      d_hold       <= '0;
      conflict_cnt <= '0;
    end else begin
      if (IF_VALID) if_hold <= MEM_RDATA;
      if (D_VALID)  d_hold  <= MEM_RDATA;
      if (IF_REQ && D_REQ && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  always_comb begin
    IF_GNT       = if_gnt;
    D_GNT        = d_gnt;
    MEM_EN       = if_gnt || d_gnt;
    MEM_WE       = d_gnt && D_WE;
    MEM_ADDR     = '0;
    if (d_gnt)       MEM_ADDR = D_ADDR;
    else if (if_gnt) MEM_ADDR = IF_ADDR;
    MEM_WDATA    = d_gnt ? D_WDATA : '0;
    IF_VALID     = (resp_owner == RESP_IF);
    D_VALID      = (resp_owner == RESP_D);
    IF_RDATA     = IF_VALID ? MEM_RDATA : if_hold;
    D_RDATA      = D_VALID  ? MEM_RDATA : d_hold;
    CONFLICT_CNT = conflict_cnt;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM emulator, transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
  localparam int SIZE = 32;
  localparam int AW   = 10;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic            IF_REQ = 1'b0, IF_GNT, IF_VALID;
  logic [AW-1:0]   IF_ADDR = '0;
  logic [SIZE-1:0] IF_RDATA;
  logic            D_REQ = 1'b0, D_WE = 1'b0, D_GNT, D_VALID;
  logic [AW-1:0]   D_ADDR = '0;
  logic [SIZE-1:0] D_WDATA = '0, D_RDATA;
  logic            MEM_EN, MEM_WE;
  logic [AW-1:0]   MEM_ADDR;
  logic [SIZE-1:0] MEM_WDATA, MEM_RDATA;
  logic [15:0]     CONFLICT_CNT;

  mem_port_arbiter #(.SIZE(SIZE), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_VALID(IF_VALID), .IF_RDATA(IF_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_VALID(D_VALID), .D_RDATA(D_RDATA),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .CONFLICT_CNT(CONFLICT_CNT)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int unsigned a);
    return (a == 4) ? 32'h0050_0093 : (32'hA500_0000 ^ (a * 32'h0001_0203));
  endfunction

  // RAM emulator: samples the strobe mid-cycle, acts on the rising edge, read data next cycle.
  logic [31:0]   ram [1024];
  logic          cap_en, cap_we;
  logic [AW-1:0] cap_addr;
  logic [31:0]   cap_wdata;
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = pat(i);
    MEM_RDATA = '0;
    forever begin
      @(negedge CLK);
      #1;
      cap_en = MEM_EN; cap_we = MEM_WE; cap_addr = MEM_ADDR; cap_wdata = MEM_WDATA;
      @(posedge CLK);
      if (cap_en) begin
        if (cap_we) ram[cap_addr] = cap_wdata;
        else        MEM_RDATA <= ram[cap_addr];
      end
    end
  end

  // Reference model: who wins, what the RAM holds, which read returns next cycle.
  logic [31:0] m_ram [1024];
  initial begin
    logic        m_last_d, ig, dg;
    int          m_pend;
    logic [31:0] m_pend_data, m_if_hold, m_d_hold;
    int unsigned m_cnt;
    for (int i = 0; i < 1024; i++) m_ram[i] = pat(i);
    m_last_d = 1'b0; m_pend = 0; m_pend_data = '0; m_if_hold = '0; m_d_hold = '0; m_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        chk("rst_if_gnt", 32'(IF_GNT), 0);     chk("rst_d_gnt", 32'(D_GNT), 0);
        chk("rst_if_valid", 32'(IF_VALID), 0); chk("rst_d_valid", 32'(D_VALID), 0);
        chk("rst_mem_en", 32'(MEM_EN), 0);     chk("rst_mem_we", 32'(MEM_WE), 0);
        chk("rst_mem_addr", 32'(MEM_ADDR), 0); chk("rst_mem_wdata", MEM_WDATA, 0);
        chk("rst_if_rdata", IF_RDATA, 0);      chk("rst_d_rdata", D_RDATA, 0);
        chk("rst_conflict_cnt", 32'(CONFLICT_CNT), 0);
        m_last_d = 1'b0; m_pend = 0; m_if_hold = '0; m_d_hold = '0; m_cnt = 0;
      end else begin
        if (IF_REQ && D_REQ) begin
          ig = m_last_d; dg = !m_last_d;
        end else begin
          ig = IF_REQ; dg = D_REQ;
        end
        chk("if_gnt", 32'(IF_GNT), 32'(ig));
        chk("d_gnt", 32'(D_GNT), 32'(dg));
        chk("mem_en", 32'(MEM_EN), 32'(ig || dg));
        chk("mem_we", 32'(MEM_WE), 32'(dg && D_WE));
        if (ig) chk("mem_addr_if", 32'(MEM_ADDR), 32'(IF_ADDR));
        if (dg) chk("mem_addr_d", 32'(MEM_ADDR), 32'(D_ADDR));
        if (dg) chk("mem_wdata", MEM_WDATA, D_WDATA);
        chk("if_valid", 32'(IF_VALID), 32'(m_pend == 1));
        chk("d_valid", 32'(D_VALID), 32'(m_pend == 2));
        chk("if_rdata", IF_RDATA, (m_pend == 1) ? m_pend_data : m_if_hold);
        chk("d_rdata", D_RDATA, (m_pend == 2) ? m_pend_data : m_d_hold);
        chk("conflict_cnt", 32'(CONFLICT_CNT), m_cnt);
        if (m_pend == 1) m_if_hold = m_pend_data;
        if (m_pend == 2) m_d_hold  = m_pend_data;
        m_pend = 0;
        if (ig) begin
          m_last_d = 1'b0; m_pend = 1; m_pend_data = m_ram[IF_ADDR];
        end else if (dg) begin
          m_last_d = 1'b1;
          if (D_WE) m_ram[D_ADDR] = D_WDATA;
          else begin m_pend = 2; m_pend_data = m_ram[D_ADDR]; end
        end
        if (IF_REQ && D_REQ && m_cnt < 65535) m_cnt++;
      end
    end
  end

  typedef struct { logic we; logic [AW-1:0] addr; logic [31:0] wdata; } dreq_t;
  logic [AW-1:0] ifq [$];
  dreq_t         dq  [$];
  byte           glog [$];

  task automatic drive_heads();
    IF_REQ  = (ifq.size() > 0);
    IF_ADDR = IF_REQ ? ifq[0] : '0;
    D_REQ   = (dq.size() > 0);
    D_WE    = D_REQ ? dq[0].we : 1'b0;
    D_ADDR  = D_REQ ? dq[0].addr : '0;
    D_WDATA = D_REQ ? dq[0].wdata : '0;
  endtask

  // Requesters hold REQ until granted; bounded by a cycle budget.
  task automatic run_queues(input int budget, output int cycles);
    cycles = 0;
    while ((ifq.size() > 0 || dq.size() > 0) && cycles < budget) begin
      @(posedge CLK); #2;
      drive_heads();
      #4;
      if (IF_GNT) begin void'(ifq.pop_front()); glog.push_back(8'h49); end
      if (D_GNT)  begin void'(dq.pop_front());  glog.push_back(8'h44); end
      cycles++;
    end
    chk("queues_drained", 32'(ifq.size() + dq.size()), 0);
    ifq.delete(); dq.delete();
  endtask

  task automatic idle();
    @(posedge CLK); #2;
    IF_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #2;
    RESET_N = 1'b0; IF_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RESET_N = 1'b1;
  endtask

  task automatic hold_both(input int n);
    @(posedge CLK); #2;
    IF_REQ = 1'b1; IF_ADDR = 10'h001; D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 10'h002;
    repeat (n) @(posedge CLK);
    #2 IF_REQ = 1'b0; D_REQ = 1'b0;
    #4;
  endtask

  function automatic logic [31:0] seq_code();
    logic [31:0] s = '0;
    foreach (glog[i]) s = {s[23:0], glog[i]};
    return s;
  endfunction

  initial begin
    int n;
    repeat (3) @(posedge CLK);
    #2 RESET_N = 1'b1;

    // Lone fetch of word 4
    ifq.push_back(10'h004);
    run_queues(4, n);
    chk("fetch_gnt_cycles", 32'(n), 1);
    idle(); #4;
    chk("fetch_valid", 32'(IF_VALID), 1);
    chk("fetch_rdata", IF_RDATA, 32'h0050_0093);
    repeat (3) idle();
    #4;
    chk("fetch_valid_once", 32'(IF_VALID), 0);
    chk("fetch_rdata_held", IF_RDATA, 32'h0050_0093);

    // First conflict after reset goes to D
    do_reset(); glog.delete();
    ifq.push_back(10'h010);
    dq.push_back('{we: 1'b0, addr: 10'h100, wdata: 32'h0});
    run_queues(4, n);
    chk("conflict_order", seq_code(), 32'h0000_4449);
    idle(); #4;
    chk("conflict_cnt_1", 32'(CONFLICT_CNT), 1);

    // Sustained conflict alternates D,I,D,I
    do_reset(); glog.delete();
    ifq.push_back(10'h030); ifq.push_back(10'h031);
    dq.push_back('{we: 1'b0, addr: 10'h200, wdata: 32'h0});
    dq.push_back('{we: 1'b0, addr: 10'h201, wdata: 32'h0});
    run_queues(8, n);
    chk("rr_order", seq_code(), 32'h4449_4449);
    idle(); #4;
    chk("conflict_cnt_3", 32'(CONFLICT_CNT), 3);

    // Store then load back
    @(posedge CLK); #2;
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 10'h020; D_WDATA = 32'hDEAD_BEEF;
    #4;
    chk("store_gnt", 32'(D_GNT), 1);
    chk("store_mem_en", 32'(MEM_EN), 1);
    chk("store_mem_we", 32'(MEM_WE), 1);
    chk("store_mem_wdata", MEM_WDATA, 32'hDEAD_BEEF);
    idle(); #4;
    chk("store_no_valid", 32'(D_VALID), 0);
    dq.push_back('{we: 1'b0, addr: 10'h020, wdata: 32'h0});
    run_queues(4, n);
    idle(); #4;
    chk("load_back_valid", 32'(D_VALID), 1);
    chk("load_back_rdata", D_RDATA, 32'hDEAD_BEEF);

    // Reset right after a load grant
    @(posedge CLK); #2;
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 10'h033;
    #4;
    chk("abort_ld_gnt", 32'(D_GNT), 1);
    #2 RESET_N = 1'b0; D_REQ = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #6;
      chk("abort_no_valid", 32'(D_VALID), 0);
    end
    chk("abort_d_rdata", D_RDATA, 0);
    chk("abort_conflict_cnt", 32'(CONFLICT_CNT), 0);

    // Counter saturation
    do_reset();
    hold_both(65534);
    chk("cnt_fffe", 32'(CONFLICT_CNT), 32'h0000_FFFE);
    hold_both(3);
    chk("cnt_saturated", 32'(CONFLICT_CNT), 32'h0000_FFFF);

    idle(); idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
